jogo_memoria_generico: RTL and testbench
========================================

// Module: jogo_memoria_generico
// PURPOSE
//  Parametrised successor of the Simon-style memory game core. Plays rounds 1..R: shows a growing
//  pseudo-random button sequence on leds, then checks player presses against it. Adds configurable
//  button count, round count, show time, per-press timeout and two selectable sequence seeds.
//  Sits between the debounced button/switch inputs and the board LEDs and 7-seg debug decoders.
// PARAMETERS
//  N_BOTOES      4     buttons/leds; power of 2, 2..16
//  MAX_RODADAS   16    rounds in full mode; 2..64
//  SHOW_CICLOS   500   clocks each sequence element is lit, also gap length between elements
//  TIMEOUT_CICLOS 3000 clocks allowed per press before timeout
//  SEED_A/SEED_B 16'hACE1/16'h1D2B  LFSR seeds; nonzero
// PORTS
//  clock            in   1   system clock (1 kHz on board)
//  reset            in   1   async, active-low; 0 = reset
//  jogar            in   1   start/restart level; start taken on rising edge
//  chaveMemoria     in   1   seed select at start: 0=SEED_A, 1=SEED_B
//  botaoDificuldade in   1   mode at start: 0=full (MAX_RODADAS), 1=easy (MAX_RODADAS/2)
//  botoes           in   N_BOTOES  player buttons, one-hot when pressed
//  leds             out  N_BOTOES  shown element during MOSTRA, else echo of botoes
//  ganhou/perdeu/timeout out 1  result flags, held until next start or reset
//  pronto           out  1   high in any final state
//  db_estado        out  4   state code; db_rodada out 6 current round-1; db_jogada out 6 press index
// BEHAVIOUR
//  Reset: state INICIAL, all outputs 0, counters 0, LFSR=SEED_A. Reset mid-game aborts immediately.
//  Start: rising edge of jogar in INICIAL or any final state -> PREPARA next clock; latch seed and
//   mode; clear flags, rodada=0. jogar edge in other states is ignored.
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1; element i = one-hot(lfsr[log2N-1:0]) after i
//   steps from seed. LFSR reloaded from latched seed at entry of MOSTRA and of ESPERA.
//  States: INICIAL(0) PREPARA(1) MOSTRA(2) APAGA(3) ESPERA(4) REGISTRA(5) COMPARA(6)
//   PROXIMA(7) GANHOU(A) PERDEU(E) TIMEOUT(F).
//  PREPARA -> MOSTRA. MOSTRA: led lit SHOW_CICLOS clocks -> APAGA (leds 0, SHOW_CICLOS clocks);
//   APAGA -> MOSTRA with next element while index<=rodada, else ESPERA, jogada=0.
//  ESPERA: press = botoes!=0 while previous sample ==0 (rising edge). Press -> REGISTRA (latch).
//   Timeout counter cleared on entry; reaching TIMEOUT_CICLOS-1 with no press -> TIMEOUT.
//  COMPARA: latched value != element, or not one-hot -> PERDEU. Match and jogada<rodada ->
//   ESPERA, jogada+1, LFSR step. Match and jogada==rodada -> PROXIMA.
//  PROXIMA: rodada==limit-1 -> GANHOU, else rodada+1 -> MOSTRA.
//  Press and timeout on same clock: press wins. Held button produces one press only.
//  Final states hold flags and pronto=1 until start edge or reset. Counters saturate-free; widths
//   $clog2 of their limits.
// CONFIGURATION
//  JOGO_MEMORIA_TIMEOUT_EN defined: timeout counter, TIMEOUT state and timeout output active.
//  Undefined: no counter logic; ESPERA waits indefinitely; timeout tied 0.
// STRUCTURE
//  jogo_memoria_defs.vh: state code localparams, LFSR tap mask, mode encodings; shared with
//   7-seg decoders and benches. Sub-module gerador_sequencia_lfsr (load, step, seed, out one-hot).
//   FSM, round/press/show/timeout counters stay in top.
// TESTING (N_BOTOES=4, MAX_RODADAS=4, SHOW_CICLOS=5, TIMEOUT_CICLOS=20, macro defined)
//  1 reset=0 mid-MOSTRA -> db_estado=0, leds=0, all flags 0 same clock (async).
//  2 jogar edge, chaveMemoria=0, correct presses all rounds -> ganhou=1, pronto=1 after round 4.
//  3 botaoDificuldade=1, correct play -> ganhou after 2 rounds, db_rodada max 1.
//  4 Round 2 second press wrong -> perdeu=1, db_estado=E, db_jogada=1.
//  5 No press 20 clocks in ESPERA -> timeout=1, db_estado=F; press on clock 19 -> no timeout.
//  6 botoes=4'b0011 pressed -> perdeu; button held 10 clocks counts once; macro undefined -> ESPERA holds 100 clocks.

Source files
------------

// File: rtl/jogo_memoria_generico_pkg.sv
// Shared definitions for the memory game: state codes (also shown on db_estado),
// LFSR tap mask, seed/mode encodings and small elaboration helpers.
package jogo_memoria_generico_pkg;

    typedef enum logic [3:0] {
        INICIAL  = 4'h0,
        PREPARA  = 4'h1,
        MOSTRA   = 4'h2,
        APAGA    = 4'h3,
        ESPERA   = 4'h4,
        REGISTRA = 4'h5,
        COMPARA  = 4'h6,
        PROXIMA  = 4'h7,
        GANHOU   = 4'hA,
        PERDEU   = 4'hE,
        TIMEOUT  = 4'hF
    } estado_t;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic        MODO_COMPLETO = 1'b0;
    localparam logic        SEL_SEED_A    = 1'b0;

    function automatic logic [15:0] lfsr_proximo(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    function automatic int unsigned largura(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/jogo_memoria_generico_lfsr.sv
// gerador_sequencia_lfsr: 16-bit Galois LFSR whose low bits select the lit button.
// Load has priority over step so a reload always restarts the sequence at element 0.
module gerador_sequencia_lfsr
    import jogo_memoria_generico_pkg::*;
#(
    parameter int unsigned N_BOTOES   = 4,
    parameter logic [15:0] SEED_RESET = 16'hACE1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [15:0]         seed_i,
    output logic [N_BOTOES-1:0] elemento_o
);
    localparam int unsigned BW = largura(N_BOTOES);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (step_i) begin
            lfsr_d = lfsr_proximo(lfsr_q);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED_RESET;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        elemento_o = '0;
        elemento_o[lfsr_q[BW-1:0]] = 1'b1;
    end

endmodule

// File: rtl/jogo_memoria_generico.sv
// jogo_memoria_generico: parametrised Simon-style memory game core (FSM and counters).
// Define JOGO_MEMORIA_TIMEOUT_EN to enable the per-press timeout counter and TIMEOUT state.
module jogo_memoria_generico
    import jogo_memoria_generico_pkg::*;
#(
    parameter int unsigned N_BOTOES       = 4,
    parameter int unsigned MAX_RODADAS    = 16,
    parameter int unsigned SHOW_CICLOS    = 500,
    parameter int unsigned TIMEOUT_CICLOS = 3000,
    parameter logic [15:0] SEED_A         = 16'hACE1,
    parameter logic [15:0] SEED_B         = 16'h1D2B
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic                chaveMemoria,
    input  logic                botaoDificuldade,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                ganhou,
    output logic                perdeu,
    output logic                timeout,
    output logic                pronto,
    output logic [3:0]          db_estado,
    output logic [5:0]          db_rodada,
    output logic [5:0]          db_jogada
);
    localparam int unsigned RW = largura(MAX_RODADAS);
    localparam int unsigned SW = largura(SHOW_CICLOS);

    estado_t             estado_q, estado_d;
    logic [RW-1:0]       rodada_q, rodada_d, jogada_q, jogada_d, idx_q, idx_d, limite;
    logic [SW-1:0]       cnt_q, cnt_d;
    logic [N_BOTOES-1:0] botao_q, botao_d, botoes_ant_q, elemento;
    logic                jogar_ant_q, seed_sel_q, seed_sel_d, modo_q, modo_d;
    logic                ganhou_q, ganhou_d, perdeu_q, perdeu_d;
    logic                inicio, pressao, carrega, avanca;
    logic [15:0]         semente;
`ifdef JOGO_MEMORIA_TIMEOUT_EN
    localparam int unsigned TW = largura(TIMEOUT_CICLOS);
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                timeout_q, timeout_d;
`endif

    assign inicio  = jogar & ~jogar_ant_q;
    assign pressao = (|botoes) & ~(|botoes_ant_q);
    assign semente = (seed_sel_q == SEL_SEED_A) ? SEED_A : SEED_B;
    assign limite  = (modo_q == MODO_COMPLETO) ? RW'(MAX_RODADAS - 1) : RW'(MAX_RODADAS / 2 - 1);

    gerador_sequencia_lfsr #(
        .N_BOTOES  (N_BOTOES),
        .SEED_RESET(SEED_A)
    ) u_lfsr (
        .clock     (clock),
        .reset     (reset),
        .load_i    (carrega),
        .step_i    (avanca),
        .seed_i    (semente),
        .elemento_o(elemento)
    );

    always_comb begin
        estado_d   = estado_q;
        rodada_d   = rodada_q;
        jogada_d   = jogada_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        botao_d    = botao_q;
        seed_sel_d = seed_sel_q;
        modo_d     = modo_q;
        ganhou_d   = ganhou_q;
        perdeu_d   = perdeu_q;
        carrega    = 1'b0;
        avanca     = 1'b0;
`ifdef JOGO_MEMORIA_TIMEOUT_EN
        // held at zero outside ESPERA, so every entry into ESPERA starts a fresh count
        tcnt_d     = '0;
        timeout_d  = timeout_q;
`endif
        case (estado_q)
            INICIAL, GANHOU, PERDEU, TIMEOUT: begin
                if (inicio) begin
                    estado_d   = PREPARA;
                    seed_sel_d = chaveMemoria;
                    modo_d     = botaoDificuldade;
                    rodada_d   = '0;
                    ganhou_d   = 1'b0;
                    perdeu_d   = 1'b0;
`ifdef JOGO_MEMORIA_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                end
            end
            PREPARA: begin
                estado_d = MOSTRA;
                carrega  = 1'b1;
                idx_d    = '0;
                cnt_d    = '0;
            end
            MOSTRA: begin
                if (cnt_q == SW'(SHOW_CICLOS - 1)) begin
                    estado_d = APAGA;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            APAGA: begin
                if (cnt_q == SW'(SHOW_CICLOS - 1)) begin
                    cnt_d = '0;
                    if (idx_q < rodada_q) begin
                        estado_d = MOSTRA;
                        idx_d    = idx_q + 1'b1;
                        avanca   = 1'b1;
                    end else begin
                        estado_d = ESPERA;
                        jogada_d = '0;
                        carrega  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ESPERA: begin
                if (pressao) begin
                    estado_d = REGISTRA;
                    botao_d  = botoes;
                end
`ifdef JOGO_MEMORIA_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CICLOS - 1)) begin
                    estado_d  = TIMEOUT;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            REGISTRA: estado_d = COMPARA;
            COMPARA: begin
                if (!$onehot(botao_q) || (botao_q != elemento)) begin
                    estado_d = PERDEU;
                    perdeu_d = 1'b1;
                end else if (jogada_q < rodada_q) begin
                    estado_d = ESPERA;
                    jogada_d = jogada_q + 1'b1;
                    avanca   = 1'b1;
                end else begin
                    estado_d = PROXIMA;
                end
            end
            PROXIMA: begin
                if (rodada_q == limite) begin
                    estado_d = GANHOU;
                    ganhou_d = 1'b1;
                end else begin
                    estado_d = MOSTRA;
                    rodada_d = rodada_q + 1'b1;
                    carrega  = 1'b1;
                    idx_d    = '0;
                    cnt_d    = '0;
                end
            end
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= INICIAL;
            rodada_q     <= '0;
            jogada_q     <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            botao_q      <= '0;
            botoes_ant_q <= '0;
            jogar_ant_q  <= 1'b0;
            seed_sel_q   <= 1'b0;
            modo_q       <= 1'b0;
            ganhou_q     <= 1'b0;
            perdeu_q     <= 1'b0;
`ifdef JOGO_MEMORIA_TIMEOUT_EN
            tcnt_q       <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            estado_q     <= estado_d;
            rodada_q     <= rodada_d;
            jogada_q     <= jogada_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            botao_q      <= botao_d;
            botoes_ant_q <= botoes;
            jogar_ant_q  <= jogar;
            seed_sel_q   <= seed_sel_d;
            modo_q       <= modo_d;
            ganhou_q     <= ganhou_d;
            perdeu_q     <= perdeu_d;
`ifdef JOGO_MEMORIA_TIMEOUT_EN
            tcnt_q       <= tcnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    always_comb begin
        case (estado_q)
            MOSTRA:  leds = elemento;
            APAGA:   leds = '0;
            default: leds = botoes;
        endcase
    end

    assign ganhou    = ganhou_q;
    assign perdeu    = perdeu_q;
`ifdef JOGO_MEMORIA_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif
    assign pronto    = (estado_q == GANHOU) || (estado_q == PERDEU) || (estado_q == TIMEOUT);
    assign db_estado = estado_q;
    assign db_rodada = 6'(rodada_q);
    assign db_jogada = 6'(jogada_q);

endmodule

// File: tb/tb_jogo_memoria_generico.sv
// Self-checking bench for jogo_memoria_generico: reference sequence from the LFSR rule,
// randomized press timing, directed win/lose/timeout/reset scenarios.
module tb_jogo_memoria_generico;
    localparam int unsigned N    = 4;
    localparam int unsigned MAXR = 4;
    localparam int unsigned SHOW = 5;
    localparam int unsigned TOUT = 20;

    localparam logic [3:0] S_INICIAL  = 4'h0;
    localparam logic [3:0] S_PREPARA  = 4'h1;
    localparam logic [3:0] S_MOSTRA   = 4'h2;
    localparam logic [3:0] S_APAGA    = 4'h3;
    localparam logic [3:0] S_ESPERA   = 4'h4;
    localparam logic [3:0] S_REGISTRA = 4'h5;
    localparam logic [3:0] S_PROXIMA  = 4'h7;
    localparam logic [3:0] S_GANHOU   = 4'hA;
    localparam logic [3:0] S_PERDEU   = 4'hE;
`ifdef JOGO_MEMORIA_TIMEOUT_EN
    localparam logic [3:0] S_TIMEOUT  = 4'hF;
`endif

    logic         clock;
    logic         reset, jogar, chaveMemoria, botaoDificuldade;
    logic [N-1:0] botoes, leds;
    logic         ganhou, perdeu, timeout, pronto;
    logic [3:0]   db_estado;
    logic [5:0]   db_rodada, db_jogada;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned seq [64];
    int unsigned mostrados = 0;
    int unsigned rodada_max = 0;
    logic [3:0]  prev_estado = 4'h0;

    jogo_memoria_generico #(
        .N_BOTOES      (N),
        .MAX_RODADAS   (MAXR),
        .SHOW_CICLOS   (SHOW),
        .TIMEOUT_CICLOS(TOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .jogar           (jogar),
        .chaveMemoria    (chaveMemoria),
        .botaoDificuldade(botaoDificuldade),
        .botoes          (botoes),
        .leds            (leds),
        .ganhou          (ganhou),
        .perdeu          (perdeu),
        .timeout         (timeout),
        .pronto          (pronto),
        .db_estado       (db_estado),
        .db_rodada       (db_rodada),
        .db_jogada       (db_jogada)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int unsigned b);
        logic [N-1:0] v;
        v = '0;
        v[b % N] = 1'b1;
        return v;
    endfunction

    // Element i is the button selected by the low bits after i LFSR steps from the seed
    task automatic gera_seq(input bit sel);
        int unsigned s;
        s = sel ? 32'h1D2B : 32'hACE1;
        for (int i = 0; i < 64; i++) begin
            seq[i] = s % N;
            s = (s >> 1) ^ (((s & 1) != 0) ? 32'hB400 : 32'h0);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (db_estado === S_MOSTRA && prev_estado !== S_MOSTRA) begin
            if (prev_estado === S_PREPARA || prev_estado === S_PROXIMA) mostrados = 0;
            check("led_mostra", 32'(leds), 32'(onehot(seq[mostrados % 64])));
            mostrados++;
        end
        if (db_estado === S_APAGA && prev_estado !== S_APAGA)
            check("led_apaga", 32'(leds), 32'h0);
        if (int'(db_rodada) > int'(rodada_max)) rodada_max = db_rodada;
        prev_estado = db_estado;
    endtask

    task automatic wait_for(input logic [3:0] alvo, input int unsigned limite, input string tag);
        int unsigned n;
        n = 0;
        while (db_estado !== alvo && n < limite) begin
            tick();
            n++;
        end
        check(tag, 32'(db_estado), 32'(alvo));
    endtask

    task automatic inicia(input bit sel, input bit modo);
        gera_seq(sel);
        rodada_max = 0;
        chaveMemoria = sel;
        botaoDificuldade = modo;
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
        chaveMemoria = ~sel;
        botaoDificuldade = ~modo;
        check("prepara", 32'(db_estado), 32'(S_PREPARA));
        check("flags_limpos", 32'({ganhou, perdeu, timeout, pronto}), 32'h0);
        check("rodada_zero", 32'(db_rodada), 32'h0);
    endtask

    task automatic aperta(input logic [N-1:0] b, input int unsigned segura);
        repeat ($urandom_range(0, 3)) tick();
        botoes = b;
        repeat (segura) tick();
        botoes = '0;
        tick();
    endtask

    task automatic joga_rodada(input int unsigned r);
        wait_for(S_ESPERA, 200, "espera_rodada");
        check("qtd_mostrados", mostrados, r + 1);
        check("db_rodada", 32'(db_rodada), r);
        for (int unsigned j = 0; j <= r; j++) begin
            if (j > 0) wait_for(S_ESPERA, 10, "espera_jogada");
            check("db_jogada", 32'(db_jogada), j);
            aperta(onehot(seq[j]), $urandom_range(1, 4));
        end
    endtask

    task automatic jogo_completo(input bit sel, input bit modo);
        int unsigned rodadas;
        rodadas = modo ? MAXR / 2 : MAXR;
        inicia(sel, modo);
        for (int unsigned r = 0; r < rodadas; r++) joga_rodada(r);
        wait_for(S_GANHOU, 10, "ganhou_estado");
        check("ganhou_flags", 32'({ganhou, perdeu, timeout, pronto}), 32'b1001);
        check("rodada_max", rodada_max, rodadas - 1);
    endtask

    initial begin
        reset = 1'b0;
        jogar = 1'b0;
        chaveMemoria = 1'b0;
        botaoDificuldade = 1'b0;
        botoes = '0;
        repeat (3) tick();
        check("reset_estado", 32'(db_estado), 32'(S_INICIAL));
        check("reset_saidas", 32'({leds, ganhou, perdeu, timeout, pronto}), 32'h0);
        check("reset_contadores", 32'({db_rodada, db_jogada}), 32'h0);
        reset = 1'b1;
        tick();

        jogo_completo(1'b0, 1'b0);
        jogo_completo(1'b0, 1'b1);
        jogo_completo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // wrong second press in round 2
        inicia(1'b1, 1'b0);
        joga_rodada(0);
        wait_for(S_ESPERA, 200, "espera_r1");
        aperta(onehot(seq[0]), 2);
        wait_for(S_ESPERA, 10, "espera_r1_j1");
        aperta(onehot(seq[1] + 1), 1);
        wait_for(S_PERDEU, 10, "perdeu_estado");
        check("perdeu_flags", 32'({ganhou, perdeu, timeout, pronto}), 32'b0101);
        check("perdeu_jogada", 32'(db_jogada), 32'h1);

        // held button counts once, then a two-button press loses
        inicia(1'b0, 1'b0);
        joga_rodada(0);
        wait_for(S_ESPERA, 200, "espera_segurado");
        aperta(onehot(seq[0]), 10);
        check("segurado_estado", 32'(db_estado), 32'(S_ESPERA));
        check("segurado_jogada", 32'(db_jogada), 32'h1);
        aperta(4'b0011, 1);
        wait_for(S_PERDEU, 10, "dois_botoes_estado");
        check("dois_botoes_perdeu", 32'(perdeu), 32'h1);

        inicia(1'b0, 1'b0);
        wait_for(S_ESPERA, 200, "espera_timeout");
`ifdef JOGO_MEMORIA_TIMEOUT_EN
        repeat (TOUT - 1) tick();
        check("espera_ultimo_ciclo", 32'(db_estado), 32'(S_ESPERA));
        tick();
        check("timeout_estado", 32'(db_estado), 32'(S_TIMEOUT));
        check("timeout_flags", 32'({ganhou, perdeu, timeout, pronto}), 32'b0011);
`else
        repeat (100) tick();
        check("espera_sem_timeout", 32'(db_estado), 32'(S_ESPERA));
        check("timeout_zero", 32'(timeout), 32'h0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
`endif

        // press on the last allowed clock beats the timeout
        inicia(1'b0, 1'b0);
        wait_for(S_ESPERA, 200, "espera_p19");
        repeat (TOUT - 1) tick();
        botoes = onehot(seq[0]);
        tick();
        check("p19_registra", 32'(db_estado), 32'(S_REGISTRA));
        check("p19_sem_timeout", 32'(timeout), 32'h0);
        botoes = '0;
        wait_for(S_MOSTRA, 20, "mostra_r1");
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
        check("jogar_ignorado", 32'(db_estado), 32'(S_MOSTRA));

        // asynchronous reset in the middle of MOSTRA
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_estado", 32'(db_estado), 32'(S_INICIAL));
        check("rst_async_saidas", 32'({leds, ganhou, perdeu, timeout, pronto}), 32'h0);
        check("rst_async_contadores", 32'({db_rodada, db_jogada}), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("pos_reset_inicial", 32'(db_estado), 32'(S_INICIAL));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
